// File: rtl/set_cond_unit_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// set_cond_unit_pkg : shared width and result-encoding constants  | rev 1.0
// ---------------------------------------------------------------------------
package set_cond_unit_pkg;

  localparam int unsigned DEF_WIDTH = 32;

  localparam logic [DEF_WIDTH-1:0] SET_TRUE  = DEF_WIDTH'(1);
  localparam logic [DEF_WIDTH-1:0] SET_FALSE = '0;

endpackage
`default_nettype wire

// File: rtl/set_cond_unit_core.sv
`default_nettype none
// ---------------------------------------------------------------------------
// set_cond_core : combinational seq/sge/sgt bits from subtraction flags;
// the ovf input exists only when SETS_OVF_EN is defined          | rev 1.0
// ---------------------------------------------------------------------------
module set_cond_core
  import set_cond_unit_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic             zf,
  input  logic             nz,
`ifdef SETS_OVF_EN
  input  logic             ovf,
`endif
  output logic             seq_bit,
  output logic             sge_bit,
  output logic             sgt_bit
);

  logic sign;
  // Only the sign of the difference matters; the remaining bits are ignored.
  logic unused_a_bits;

`ifdef SETS_OVF_EN
  assign sign = a[WIDTH-1] ^ ovf;
`else
  assign sign = a[WIDTH-1];
`endif

  assign unused_a_bits = ^a[WIDTH-2:0];

  assign seq_bit = zf;
  assign sge_bit = ~sign;
  assign sgt_bit = nz & ~sign;

endmodule
`default_nettype wire

// File: rtl/set_cond_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// set_cond_unit : registered 1-cycle seq/sge/sgt result words; optional
// overflow-corrected sign selected by SETS_OVF_EN                 | rev 1.0
// ---------------------------------------------------------------------------
module set_cond_unit
  import set_cond_unit_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic             zf,
  input  logic             nz,
`ifdef SETS_OVF_EN
  input  logic             ovf,
`endif
  output logic             out_valid,
  output logic [WIDTH-1:0] seq,
  output logic [WIDTH-1:0] sge,
  output logic [WIDTH-1:0] sgt
);

  localparam logic [WIDTH-1:0] RES_TRUE  = WIDTH'(SET_TRUE);
  localparam logic [WIDTH-1:0] RES_FALSE = WIDTH'(SET_FALSE);

  logic             seq_bit, sge_bit, sgt_bit;
  logic [WIDTH-1:0] seq_d, sge_d, sgt_d;
  logic [WIDTH-1:0] seq_q, sge_q, sgt_q;
  logic             out_valid_d, out_valid_q;

  set_cond_core #(.WIDTH(WIDTH)) u_core (
    .a       (a),
    .zf      (zf),
    .nz      (nz),
`ifdef SETS_OVF_EN
    .ovf     (ovf),
`endif
    .seq_bit (seq_bit),
    .sge_bit (sge_bit),
    .sgt_bit (sgt_bit)
  );

  // Result words hold their last value while no new operands arrive.
  always_comb begin
    seq_d       = seq_q;
    sge_d       = sge_q;
    sgt_d       = sgt_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      seq_d = seq_bit ? RES_TRUE : RES_FALSE;
      sge_d = sge_bit ? RES_TRUE : RES_FALSE;
      sgt_d = sgt_bit ? RES_TRUE : RES_FALSE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seq_q       <= '0;
      sge_q       <= '0;
      sgt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      seq_q       <= seq_d;
      sge_q       <= sge_d;
      sgt_q       <= sgt_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign seq       = seq_q;
  assign sge       = sge_q;
  assign sgt       = sgt_q;
  assign out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_set_cond_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_set_cond_unit : directed plus randomized checks of set_cond_unit
// against an operand-level compare model                          | rev 1.0
// ---------------------------------------------------------------------------
module tb_set_cond_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] a;
  logic         zf;
  logic         nz;
  logic         ovf;
  logic         out_valid;
  logic [W-1:0] seq, sge, sgt;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: what the outputs should show after each edge.
  logic [W-1:0] m_seq, m_sge, m_sgt;
  logic         m_valid;

  always #5 clk = ~clk;

  set_cond_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .zf        (zf),
    .nz        (nz),
`ifdef SETS_OVF_EN
    .ovf       (ovf),
`endif
    .out_valid (out_valid),
    .seq       (seq),
    .sge       (sge),
    .sgt       (sgt)
  );

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs with the compare outcome the operands imply,
  // advance the model one edge, then check every output.
  task automatic cycle(input string tag, input bit r, input bit v, input logic [W-1:0] av,
                       input bit z, input bit n, input bit o,
                       input bit e_eq, input bit e_ge, input bit e_gt);
    rst = r; in_valid = v; a = av; zf = z; nz = n; ovf = o;
    @(posedge clk);
    #1;
    if (r) begin
      m_seq = '0; m_sge = '0; m_sgt = '0; m_valid = 1'b0;
    end else begin
      m_valid = v;
      if (v) begin
        m_seq = W'(e_eq);
        m_sge = W'(e_ge);
        m_sgt = W'(e_gt);
      end
    end
    check({tag, ".valid"}, W'(out_valid), W'(m_valid));
    check({tag, ".seq"},   seq, m_seq);
    check({tag, ".sge"},   sge, m_sge);
    check({tag, ".sgt"},   sgt, m_sgt);
  endtask

  initial begin
    int      x, y, d, kind;
    bit      r, v, o, z, n, ge;
    logic [W-1:0] av;

    m_seq = '0; m_sge = '0; m_sgt = '0; m_valid = 1'b0;
    rst = 1'b1; in_valid = 1'b1; a = 32'h1; zf = 1'b0; nz = 1'b1; ovf = 1'b0;

    // Reset dominates even with valid operands present.
    cycle("reset0", 1, 1, 32'h1, 0, 1, 0, 0, 1, 1);
    cycle("reset1", 1, 1, 32'h1, 0, 1, 0, 0, 1, 1);

    cycle("equal",   0, 1, 32'h00000000, 1, 0, 0, 1, 1, 0);
    cycle("greater", 0, 1, 32'h00000001, 0, 1, 0, 0, 1, 1);
    cycle("less",    0, 1, 32'hFFFFFFFF, 0, 1, 0, 0, 0, 0);
    cycle("greater2",0, 1, 32'h00000001, 0, 1, 0, 0, 1, 1);
    cycle("hold",    0, 0, 32'hFFFFFFFF, 0, 1, 0, 0, 0, 0);
    cycle("flags11", 0, 1, 32'h00000005, 1, 1, 0, 1, 1, 1);
`ifdef SETS_OVF_EN
    cycle("ovf",     0, 1, 32'h80000000, 0, 1, 1, 0, 1, 1);
`else
    cycle("ovf",     0, 1, 32'h80000000, 0, 1, 0, 0, 0, 0);
`endif
    cycle("midrst",  1, 1, 32'h00000000, 1, 0, 0, 1, 1, 0);
    cycle("afterrst",0, 1, 32'h00000000, 1, 0, 0, 1, 1, 0);

    for (int i = 0; i < 400; i++) begin
      r    = ($urandom_range(0, 24) == 0);
      v    = ($urandom_range(0, 3) != 0);
      kind = int'($urandom_range(0, 3));
      if (kind == 0) begin
        // Arbitrary flags: seq follows zf, sgt needs nz and a non-negative difference.
        av = W'($urandom);
        z  = 1'(($urandom));
        n  = 1'(($urandom));
`ifdef SETS_OVF_EN
        o  = 1'(($urandom));
`else
        o  = 1'b0;
`endif
        ge = o ? ($signed(av) < 0) : ($signed(av) >= 0);
        cycle("rand_flags", r, v, av, z, n, o, z, ge, n && ge);
      end else begin
`ifdef SETS_OVF_EN
        x = int'($urandom);
        y = (kind == 1) ? x : int'($urandom);
        d = x - y;
        o = ((longint'(x) - longint'(y)) != longint'(d));
`else
        x = int'($urandom) >>> 2;
        y = (kind == 1) ? x : (int'($urandom) >>> 2);
        d = x - y;
        o = 1'b0;
`endif
        cycle("rand_cmp", r, v, W'(d), x == y, x != y, o, x == y, x >= y, x > y);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
